// File: rtl/led_walker_pkg.sv
// led_walker shared types and default parameters.
// Imported by the LED walker top and its tick sub-module.
package led_walker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 24;
  localparam int unsigned DEF_NLEDS = 8;

endpackage

// File: rtl/msb_edge_tick.sv
// Rising-edge detector on a counter MSB.
// Reusable tick source for any blinky-counter consumer.
module msb_edge_tick (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  output logic o_tick
);

  logic msb_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      msb_q <= 1'b0;
    end else begin
      msb_q <= i_bit;
    end
  end

  assign o_tick = i_bit & ~msb_q;

endmodule

// File: rtl/led_walker.sv
// Knight Rider LED sweep stepped by the blinky counter MSB.
// Define LED_WALKER_LOOP_EN for continuous looping with i_stop.
module led_walker
  import led_walker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NLEDS = DEF_NLEDS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_counter,
  input  logic             i_start,
`ifdef LED_WALKER_LOOP_EN
  input  logic             i_stop,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [NLEDS-1:0] o_led
);

  localparam logic [NLEDS-1:0] LED0 = NLEDS'(1);

  state_t           state_q, state_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             tick;
  logic             unused_cnt;

  assign unused_cnt = ^i_counter[WIDTH-2:0];

  msb_edge_tick u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_bit   (i_counter[WIDTH-1]),
    .o_tick  (tick)
  );

`ifdef LED_WALKER_LOOP_EN
  logic stop_q, stop_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    o_done  = 1'b0;
`ifdef LED_WALKER_LOOP_EN
    stop_d  = stop_q;
    if (state_q != IDLE) begin
      stop_d = stop_q | i_stop;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FWD;
          led_d   = LED0;
`ifdef LED_WALKER_LOOP_EN
          stop_d  = 1'b0;
`endif
        end
      end
      FWD: begin
        if (tick) begin
          // Bounce at the top without repeating the MSB position.
          if (led_q[NLEDS-1]) begin
            state_d = BWD;
            led_d   = led_q >> 1;
          end else begin
            led_d   = led_q << 1;
          end
        end
      end
      BWD: begin
        if (tick) begin
          if (led_q[0]) begin
            o_done  = 1'b1;
            state_d = IDLE;
            led_d   = '0;
`ifdef LED_WALKER_LOOP_EN
            if (!(stop_q | i_stop)) begin
              state_d = FWD;
              led_d   = LED0;
              stop_d  = 1'b0;
            end
`endif
          end else begin
            led_d = led_q >> 1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
  end

  assign o_busy = (state_q != IDLE);
  assign o_led  = led_q;

endmodule

// File: tb/tb_led_walker.sv
// Self-checking bench for led_walker (WIDTH=4, NLEDS=4).
// Works with or without LED_WALKER_LOOP_EN defined.
module tb_led_walker;

  localparam int W    = 4;
  localparam int NL   = 4;
  localparam int LAST = 2 * (NL - 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b1;
  logic [W-1:0]  cnt   = '0;
  logic [NL-1:0] led;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1'b1;

  led_walker #(.WIDTH(W), .NLEDS(NL)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_counter (cnt),
    .i_start   (start),
`ifdef LED_WALKER_LOOP_EN
    .i_stop    (stop),
`endif
    .o_busy    (busy),
    .o_done    (done),
    .o_led     (led)
  );

  // Reference: sweep as a step index 0..LAST, position folded back.
  logic          m_act  = 1'b0;
  logic          m_msb  = 1'b0;
  logic          m_stop = 1'b0;
  int            m_k    = 0;
  int            m_pos;
  logic          m_tick;
  logic          m_done;
  logic [NL-1:0] m_led;

  always_comb begin
    m_tick = cnt[W-1] & ~m_msb;
    m_pos  = (m_k < NL) ? m_k : LAST - m_k;
    m_led  = m_act ? (NL'(1) << m_pos) : '0;
    m_done = m_act && m_tick && (m_k == LAST);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_k    <= 0;
      m_msb  <= 1'b0;
      m_stop <= 1'b0;
    end else begin
      m_msb <= cnt[W-1];
      if (!m_act) begin
        if (start) begin
          m_act  <= 1'b1;
          m_k    <= 0;
          m_stop <= 1'b0;
        end
      end else begin
        if (stop) m_stop <= 1'b1;
        if (m_tick) begin
          if (m_k < LAST) begin
            m_k <= m_k + 1;
          end else begin
`ifdef LED_WALKER_LOOP_EN
            if (!(m_stop || stop)) begin
              m_k    <= 0;
              m_stop <= 1'b0;
            end else begin
              m_act <= 1'b0;
            end
`else
            m_act <= 1'b0;
`endif
          end
        end
      end
    end
  end

  task automatic tstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tstep();
      n++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tstep();
      n_cmp++;
      if (led !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: led=%b busy=%b done=%b want 0/0/0",
                 led, busy, done);
      end
    end
    rst_n = 1'b1;
    tstep();
  endtask

  task automatic test_sweep();
    logic [NL-1:0] seq[$];
    logic [NL-1:0] want[$];
    logic [NL-1:0] last;
    int dones = 0;
    int n = 0;
    want = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    wait_idle();
    repeat ($urandom_range(0, 20)) tstep();
    start = 1'b1;
    tstep();
    start = 1'b0;
    n_cmp++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_start: led=%b busy=%b want 0001/1", led, busy);
    end
    last = led;
    while (busy && n < 200) begin
      n_cmp++;
      if (led !== m_led || busy !== m_act || done !== m_done) begin
        n_bad++;
        $display("FAIL sweep_model: led=%b busy=%b done=%b want %b/%b/%b",
                 led, busy, done, m_led, m_act, m_done);
      end
      if (done) begin
        dones++;
        n_cmp++;
        if (led !== 4'b0001) begin
          n_bad++;
          $display("FAIL done_pos: led=%b at done, want 0001", led);
        end
      end
      tstep();
      n++;
      if (led !== last) seq.push_back(led);
      last = led;
    end
    n_cmp++;
    if (seq != want) begin
      n_bad++;
      $display("FAIL sweep_seq: got %p want %p", seq, want);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL sweep_dones: got %0d want 1", dones);
    end
  endtask

  task automatic test_start_on_tick();
    int n = 0;
    wait_idle();
    while (!(cnt == 4'd8 && m_tick) && n < 40) begin
      tstep();
      n++;
    end
    start = 1'b1;
    tstep();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (led !== 4'b0001) begin
        n_bad++;
        $display("FAIL tick_start_hold[%0d]: led=%b want 0001", i, led);
      end
      tstep();
    end
    n_cmp++;
    if (led !== 4'b0010) begin
      n_bad++;
      $display("FAIL tick_start_step: led=%b want 0010", led);
    end
    wait_idle();
  endtask

  task automatic test_start_busy();
    int n = 0;
    int dones = 0;
    wait_idle();
    start = 1'b1;
    tstep();
    start = 1'b0;
    while (led !== 4'b0100 && n < 100) begin
      tstep();
      n++;
    end
    start = 1'b1;
    tstep();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n_cmp++;
      if (led !== m_led || busy !== m_act || done !== m_done) begin
        n_bad++;
        $display("FAIL busy_start_model: led=%b busy=%b done=%b want %b/%b/%b",
                 led, busy, done, m_led, m_act, m_done);
      end
      if (done) dones++;
      tstep();
      n++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL busy_start_dones: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wait_idle();
    start = 1'b1;
    tstep();
    start = 1'b0;
    while (led !== 4'b1000 && n < 100) begin
      tstep();
      n++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: led=%b busy=%b done=%b want 0/0/0",
               led, busy, done);
    end
    tstep();
    tstep();
    rst_n = 1'b1;
    tstep();
    start = 1'b1;
    tstep();
    start = 1'b0;
    n_cmp++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_restart: led=%b busy=%b want 0001/1", led, busy);
    end
    wait_idle();
  endtask

`ifdef LED_WALKER_LOOP_EN
  task automatic test_loop();
    int dones = 0;
    int drops = 0;
    int n = 0;
    wait_idle();
    stop  = 1'b0;
    start = 1'b1;
    tstep();
    start = 1'b0;
    for (int i = 0; i < 344; i++) begin
      if (busy !== 1'b1) drops++;
      if (done) dones++;
      tstep();
    end
    n_cmp++;
    if (dones != 3 || drops != 0) begin
      n_bad++;
      $display("FAIL loop_run: dones=%0d drops=%0d want 3/0", dones, drops);
    end
    repeat (30) tstep();
    stop = 1'b1;
    tstep();
    stop  = 1'b0;
    dones = 0;
    while (busy && n < 200) begin
      if (done) dones++;
      tstep();
      n++;
    end
    n_cmp++;
    if (dones != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_stop: dones=%0d busy=%b want 1/0", dones, busy);
    end
    stop = 1'b1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      n_cmp++;
      if (led !== m_led || busy !== m_act || done !== m_done ||
          $countones(led) > 1) begin
        n_bad++;
        $display("FAIL random[%0d]: led=%b busy=%b done=%b want %b/%b/%b",
                 i, led, busy, done, m_led, m_act, m_done);
      end
      start = ($urandom_range(0, 15) == 0);
`ifdef LED_WALKER_LOOP_EN
      stop = ($urandom_range(0, 7) == 0);
`endif
      tstep();
    end
    start = 1'b0;
    stop  = 1'b1;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sweep();
    test_start_on_tick();
    test_start_busy();
    test_reset_mid();
`ifdef LED_WALKER_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
